sdp_ram: RTL and testbench
==========================

// Module: sdp_ram
// PURPOSE
// - Single-clock simple dual-port RAM: port A write-only, port B read-only, both on clka.
// - Storage primitive behind the synchronous FIFO: latency 1 = block-RAM style, latency 0 = distributed/LUT style.
// - Portable RTL model for simulation and inference. No ECC, no sleep, no independent clock.
// PARAMETERS
// - ADDR_WIDTH_A        5        write address width
// - ADDR_WIDTH_B        5        read address width; must equal ADDR_WIDTH_A
// - WRITE_DATA_WIDTH_A  8        write word width
// - READ_DATA_WIDTH_B   8        read word width; must equal WRITE_DATA_WIDTH_A
// - BYTE_WRITE_WIDTH_A  8        write-enable granularity; equals WRITE_DATA_WIDTH_A (word writes), or 8 (byte lanes)
// - MEMORY_SIZE         256      total bits; DEPTH = MEMORY_SIZE / WRITE_DATA_WIDTH_A
// - READ_LATENCY_B      1        0, 1 or 2 clka cycles from addrb to doutb
// - READ_RESET_VALUE_B  0        value loaded into the doutb output register by rstb
// PORTS
// - clka     in   1                  the only clock, rising edge
// - rstb     in   1                  synchronous, active-high reset of the port-B output register only
// - ena      in   1                  port A enable; a write needs ena=1
// - wea      in   WDW/BWW            per-lane write enables; 1 bit when BWW == WDW
// - addra    in   ADDR_WIDTH_A       write address
// - dina     in   WRITE_DATA_WIDTH_A write data
// - enb      in   1                  port B read enable
// - regceb   in   1                  output-register clock enable; used only when READ_LATENCY_B = 2
// - addrb    in   ADDR_WIDTH_B       read address
// - doutb    out  READ_DATA_WIDTH_B  read data
// BEHAVIOUR
// - Array mem[0:DEPTH-1] is zero at time 0. rstb never clears the array.
// - Write: at posedge clka, if ena, for each lane i with wea[i]=1: mem[addra] lane i <= dina lane i.
//   Lane i = bits [i*BWW +: BWW].
// - Addresses >= DEPTH: writes are ignored, reads return 0.
// - Latency 0:
//   - doutb = mem[addrb], combinational. enb, regceb and rstb have no effect.
//   - A write becomes visible on doutb immediately after the writing edge.
// - Latency 1, at posedge clka, by priority:
//   - rstb: doutb <= READ_RESET_VALUE_B
//   - else enb: doutb <= mem[addrb]
//   - else: doutb holds
//   - regceb is ignored.
// - Latency 2, at posedge clka:
//   - Stage register s1 <= mem[addrb] when enb. s1 is not reset.
//   - Output doutb: rstb loads READ_RESET_VALUE_B; else regceb loads s1; else holds.
// - Reset value of doutb (latency >= 1): X/0 until the first rstb; READ_RESET_VALUE_B after rstb.
// - Collision (same address written and read on the same edge) is read-first:
//   - the read returns the pre-write contents;
//   - the new data is returned on the next read.
// - rstb together with enb: reset wins, and the read is discarded.
//   - A write on the same edge still completes.
// - Asserting rstb mid-stream loses only the output register; the array contents are preserved.
// - Addresses wrap naturally within ADDR_WIDTH. No full/empty tracking (owned by the FIFO).
// TESTING
// - Lat1: write 0xA5 @3 at edge N; enb=1, addrb=3 at edge N+1 -> doutb = 0xA5 after edge N+1; doutb unchanged after edge N.
// - Lat1 collision: mem[5]=0x11; same edge wea=1 dina=0x22 @5 and enb=1 addrb=5 -> doutb = 0x11; next read @5 -> 0x22.
// - Lat1: doutb = 0x5A; rstb=1 and enb=1 for one edge -> doutb = 0x00; then read @3 -> 0xA5 (array kept); enb=0 -> doutb holds.
// - Lat0: write 0x3C @7; addrb=7 -> doutb = 0x3C right after the edge; addrb=3 -> doutb = 0xA5 with no clock edge.
// - Byte lanes: WDW=16, BWW=8; mem[2]=0x1234; wea=2'b10, dina=0xBEEF -> read @2 = 0xBE34; ena=0 with wea=2'b11 -> no change.
// - Full sweep: write addr^0x55 to all 32 addresses, read back all 32 at latencies 0/1/2 -> every word matches; latency 2 needs regceb=1.

Source files
------------

// File: rtl/sdp_ram_if.sv
// Port bundle for the simple dual-port RAM: write port A, read port B.
// The master drives addresses, data and enables; the RAM (slave) drives read data.
interface sdp_ram_if #(
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int NLANE = 1
);
    logic             ena;
    logic [NLANE-1:0] wea;
    logic [AW-1:0]    addra;
    logic [DW-1:0]    dina;
    logic             enb;
    logic             regceb;
    logic [AW-1:0]    addrb;
    logic [DW-1:0]    doutb;

    modport master (
        output ena, wea, addra, dina, enb, regceb, addrb,
        input  doutb
    );

    modport slave (
        input  ena, wea, addra, dina, enb, regceb, addrb,
        output doutb
    );
endinterface

// File: rtl/sdp_ram.sv
// Single-clock simple dual-port RAM with lane write enables and a read latency of 0, 1 or 2.
// Read-first on same-address collisions; rstb clears only the output register.
module sdp_ram #(
    parameter int ADDR_WIDTH_A       = 5,
    parameter int ADDR_WIDTH_B       = 5,
    parameter int WRITE_DATA_WIDTH_A = 8,
    parameter int READ_DATA_WIDTH_B  = 8,
    parameter int BYTE_WRITE_WIDTH_A = 8,
    parameter int MEMORY_SIZE        = 256,
    parameter int READ_LATENCY_B     = 1,
    parameter logic [READ_DATA_WIDTH_B-1:0] READ_RESET_VALUE_B = '0
) (
    input  logic     clka,
    input  logic     rstb,
    sdp_ram_if.slave bus
);
    localparam int DEPTH = MEMORY_SIZE / WRITE_DATA_WIDTH_A;
    localparam int NLANE = WRITE_DATA_WIDTH_A / BYTE_WRITE_WIDTH_A;
    localparam int BWW   = BYTE_WRITE_WIDTH_A;

    logic [WRITE_DATA_WIDTH_A-1:0] r_mem [DEPTH] = '{default: '0};

    logic                         w_wr_ok;
    logic                         w_rd_ok;
    logic [READ_DATA_WIDTH_B-1:0] w_rd_data;
    logic                         w_unused_ok;

    assign w_wr_ok   = int'(bus.addra) < DEPTH;
    assign w_rd_ok   = int'(bus.addrb) < DEPTH;
    assign w_rd_data = w_rd_ok ? r_mem[bus.addrb] : '0;

    // Depending on latency some controls have no effect; tie them off here.
    assign w_unused_ok = &{1'b0, rstb, bus.enb, bus.regceb};

    always_ff @(posedge clka) begin
        if (bus.ena && w_wr_ok) begin
            for (int i = 0; i < NLANE; i++) begin
                if (bus.wea[i]) begin
                    r_mem[bus.addra][i*BWW +: BWW] <= bus.dina[i*BWW +: BWW];
                end
            end
        end
    end

    generate
        if (READ_LATENCY_B == 0) begin : g_lat0
            assign bus.doutb = w_rd_data;
        end else if (READ_LATENCY_B == 1) begin : g_lat1
            logic [READ_DATA_WIDTH_B-1:0] r_dout;

            // w_rd_data is sampled before this edge's write lands: read-first.
            always_ff @(posedge clka) begin
                if (rstb) begin
                    r_dout <= READ_RESET_VALUE_B;
                end else if (bus.enb) begin
                    r_dout <= w_rd_data;
                end
            end

            assign bus.doutb = r_dout;
        end else begin : g_lat2
            logic [READ_DATA_WIDTH_B-1:0] r_s1;
            logic [READ_DATA_WIDTH_B-1:0] r_dout;

            always_ff @(posedge clka) begin
                if (bus.enb) begin
                    r_s1 <= w_rd_data;
                end
            end

            always_ff @(posedge clka) begin
                if (rstb) begin
                    r_dout <= READ_RESET_VALUE_B;
                end else if (bus.regceb) begin
                    r_dout <= r_s1;
                end
            end

            assign bus.doutb = r_dout;
        end
    endgenerate
endmodule

// File: tb/tb_sdp_ram.sv
// Directed checks of sdp_ram at latencies 0/1/2 and with 8-bit byte lanes on a 16-bit word.
`timescale 1ns/1ps
module tb_sdp_ram;
    logic clka = 1'b0;
    logic rstb = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clka = ~clka;

    sdp_ram_if #(.AW(5), .DW(8),  .NLANE(1)) if_l0 ();
    sdp_ram_if #(.AW(5), .DW(8),  .NLANE(1)) if_l1 ();
    sdp_ram_if #(.AW(5), .DW(8),  .NLANE(1)) if_l2 ();
    sdp_ram_if #(.AW(5), .DW(16), .NLANE(2)) if_bw ();

    sdp_ram #(.READ_LATENCY_B(0)) u_l0 (.clka(clka), .rstb(rstb), .bus(if_l0));
    sdp_ram #(.READ_LATENCY_B(1)) u_l1 (.clka(clka), .rstb(rstb), .bus(if_l1));
    sdp_ram #(.READ_LATENCY_B(2), .READ_RESET_VALUE_B(8'hC3))
        u_l2 (.clka(clka), .rstb(rstb), .bus(if_l2));
    sdp_ram #(
        .WRITE_DATA_WIDTH_A(16), .READ_DATA_WIDTH_B(16), .BYTE_WRITE_WIDTH_A(8),
        .MEMORY_SIZE(512), .READ_LATENCY_B(1)
    ) u_bw (.clka(clka), .rstb(rstb), .bus(if_bw));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic idle_all();
        if_l0.ena = 0; if_l0.wea = '0; if_l0.addra = '0; if_l0.dina = '0;
        if_l0.enb = 0; if_l0.regceb = 0; if_l0.addrb = '0;
        if_l1.ena = 0; if_l1.wea = '0; if_l1.addra = '0; if_l1.dina = '0;
        if_l1.enb = 0; if_l1.regceb = 0; if_l1.addrb = '0;
        if_l2.ena = 0; if_l2.wea = '0; if_l2.addra = '0; if_l2.dina = '0;
        if_l2.enb = 0; if_l2.regceb = 0; if_l2.addrb = '0;
        if_bw.ena = 0; if_bw.wea = '0; if_bw.addra = '0; if_bw.dina = '0;
        if_bw.enb = 0; if_bw.regceb = 0; if_bw.addrb = '0;
    endtask

    initial begin
        logic [7:0] exp8;

        idle_all();
        #1;
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        chk_eq("rst_l1", 32'(if_l1.doutb), 32'h00);
        chk_eq("rst_l2", 32'(if_l2.doutb), 32'hC3);
        chk_eq("rst_bw", 32'(if_bw.doutb), 32'h0000);
        chk_eq("rst_l0_zero", 32'(if_l0.doutb), 32'h00);

        // Latency 1: write at edge N is not seen at N, seen by a read at N+1.
        if_l1.ena = 1; if_l1.wea = 1'b1; if_l1.addra = 5'd3; if_l1.dina = 8'hA5;
        tick();
        chk_eq("l1_wr_no_out", 32'(if_l1.doutb), 32'h00);
        if_l1.ena = 0; if_l1.enb = 1; if_l1.addrb = 5'd3;
        tick();
        chk_eq("l1_rd3", 32'(if_l1.doutb), 32'hA5);

        // Latency 1 collision: read-first.
        if_l1.enb = 0; if_l1.ena = 1; if_l1.addra = 5'd5; if_l1.dina = 8'h11;
        tick();
        if_l1.dina = 8'h22; if_l1.enb = 1; if_l1.addrb = 5'd5;
        tick();
        chk_eq("l1_coll_old", 32'(if_l1.doutb), 32'h11);
        if_l1.ena = 0;
        tick();
        chk_eq("l1_coll_new", 32'(if_l1.doutb), 32'h22);

        // Latency 1 reset: output cleared, array kept, concurrent write completes.
        if_l1.enb = 0; if_l1.ena = 1; if_l1.addra = 5'd9; if_l1.dina = 8'h5A;
        tick();
        if_l1.ena = 0; if_l1.enb = 1; if_l1.addrb = 5'd9;
        tick();
        chk_eq("l1_rd9", 32'(if_l1.doutb), 32'h5A);
        rstb = 1; if_l1.ena = 1; if_l1.addra = 5'd10; if_l1.dina = 8'h77;
        tick();
        rstb = 0; if_l1.ena = 0;
        chk_eq("l1_rst_wins", 32'(if_l1.doutb), 32'h00);
        chk_eq("l2_rst_mid", 32'(if_l2.doutb), 32'hC3);
        if_l1.addrb = 5'd3;
        tick();
        chk_eq("l1_kept3", 32'(if_l1.doutb), 32'hA5);
        if_l1.addrb = 5'd10;
        tick();
        chk_eq("l1_wr_in_rst", 32'(if_l1.doutb), 32'h77);
        if_l1.enb = 0; if_l1.addrb = 5'd5;
        tick();
        chk_eq("l1_hold", 32'(if_l1.doutb), 32'h77);

        // Latency 0: combinational read, write visible right after its edge.
        if_l0.ena = 1; if_l0.wea = 1'b1; if_l0.addra = 5'd3; if_l0.dina = 8'hA5;
        tick();
        if_l0.addra = 5'd7; if_l0.dina = 8'h3C; if_l0.addrb = 5'd7;
        #1;
        chk_eq("l0_pre_wr", 32'(if_l0.doutb), 32'h00);
        tick();
        if_l0.ena = 0;
        chk_eq("l0_post_wr", 32'(if_l0.doutb), 32'h3C);
        if_l0.addrb = 5'd3;
        #1;
        chk_eq("l0_comb3", 32'(if_l0.doutb), 32'hA5);

        // Byte lanes on a 16-bit word.
        if_bw.ena = 1; if_bw.wea = 2'b11; if_bw.addra = 5'd2; if_bw.dina = 16'h1234;
        tick();
        if_bw.wea = 2'b10; if_bw.dina = 16'hBEEF;
        tick();
        if_bw.ena = 0; if_bw.wea = 2'b11; if_bw.dina = 16'hFFFF;
        tick();
        if_bw.wea = 2'b00; if_bw.enb = 1; if_bw.addrb = 5'd2;
        tick();
        chk_eq("bw_hi_lane", 32'(if_bw.doutb), 32'hBE34);
        if_bw.enb = 0; if_bw.ena = 1; if_bw.wea = 2'b01; if_bw.dina = 16'hAA55;
        tick();
        if_bw.ena = 0; if_bw.wea = 2'b00; if_bw.enb = 1;
        tick();
        chk_eq("bw_lo_lane", 32'(if_bw.doutb), 32'hBE55);

        // Latency 2: stage register loads on enb, output on regceb.
        if_l2.ena = 1; if_l2.wea = 1'b1; if_l2.addra = 5'd4; if_l2.dina = 8'h66;
        tick();
        if_l2.ena = 0; if_l2.enb = 1; if_l2.addrb = 5'd4; if_l2.regceb = 0;
        tick();
        chk_eq("l2_no_regce", 32'(if_l2.doutb), 32'hC3);
        if_l2.enb = 0; if_l2.regceb = 1;
        tick();
        chk_eq("l2_regce", 32'(if_l2.doutb), 32'h66);
        rstb = 1;
        tick();
        rstb = 0;
        chk_eq("l2_rst", 32'(if_l2.doutb), 32'hC3);
        if_l2.regceb = 0;

        // Full sweep at all three latencies.
        if_l0.ena = 1; if_l1.ena = 1; if_l2.ena = 1;
        if_l0.wea = 1'b1; if_l1.wea = 1'b1; if_l2.wea = 1'b1;
        for (int a = 0; a < 32; a++) begin
            exp8 = 8'(a) ^ 8'h55;
            if_l0.addra = 5'(a); if_l0.dina = exp8;
            if_l1.addra = 5'(a); if_l1.dina = exp8;
            if_l2.addra = 5'(a); if_l2.dina = exp8;
            tick();
        end
        if_l0.ena = 0; if_l1.ena = 0; if_l2.ena = 0;
        if_l1.enb = 1; if_l2.enb = 1; if_l2.regceb = 1;
        for (int a = 0; a <= 32; a++) begin
            if_l0.addrb = 5'(a); if_l1.addrb = 5'(a); if_l2.addrb = 5'(a);
            #1;
            if (a < 32) chk_eq($sformatf("sw_l0_%0d", a), 32'(if_l0.doutb), 32'(8'(a) ^ 8'h55));
            tick();
            if (a < 32) chk_eq($sformatf("sw_l1_%0d", a), 32'(if_l1.doutb), 32'(8'(a) ^ 8'h55));
            if (a >= 1) chk_eq($sformatf("sw_l2_%0d", a - 1), 32'(if_l2.doutb), 32'(8'(a - 1) ^ 8'h55));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
